// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider.
// Holds the FSM state encoding and the default operand width.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    LOAD      = 3'd1,
    SHIFT     = 3'd2,
    TRIAL     = 3'd3,
    DONE_WAIT = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division trial step.
// Subtracts the divisor from the partial remainder and keeps the difference only when no borrow occurs.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial_s;

  // The top bit of trial_s is the borrow; when it is set, the old remainder is restored.
  always_comb begin
    trial_s = r - {1'b0, divisor};
    if (trial_s[WIDTH] == 1'b0) begin
      r_next = trial_s;
      q_bit  = 1'b1;
    end else begin
      r_next = r;
      q_bit  = 1'b0;
    end
  end

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider.
// Computes one quotient bit per SHIFT/TRIAL pair and registers its results on entry to DONE_WAIT.
module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   r_next_s;
  logic             q_bit_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r       (r_q),
    .divisor (divisor_q),
    .r_next  (r_next_s),
    .q_bit   (q_bit_s)
  );

  // Next-state, datapath and result-register logic.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    count_d     = count_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      HOLD: begin
        if (run) begin
          state_d = LOAD;
        end else begin
          state_d = HOLD;
        end
      end
      LOAD: begin
        divisor_d = divisor;
        r_d       = '0;
        q_d       = dividend;
        count_d   = '0;
        if (divisor == '0) begin
          state_d     = DONE_WAIT;
          quotient_d  = '1;
          remainder_d = dividend;
          dbz_d       = 1'b1;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        r_d     = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        q_d     = {q_q[WIDTH-2:0], 1'b0};
        state_d = TRIAL;
      end
      TRIAL: begin
        r_d = r_next_s;
        q_d = {q_q[WIDTH-1:1], q_bit_s};
        if (count_q < LAST_CNT) begin
          count_d = count_q + CNT_W'(1);
          state_d = SHIFT;
        end else begin
          state_d     = DONE_WAIT;
          quotient_d  = {q_q[WIDTH-1:1], q_bit_s};
          remainder_d = r_next_s[WIDTH-1:0];
          dbz_d       = 1'b0;
        end
      end
      DONE_WAIT: begin
        if (run) begin
          state_d = DONE_WAIT;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = HOLD;
      end
    endcase
    busy_d = (state_d == LOAD) || (state_d == SHIFT) || (state_d == TRIAL);
    done_d = (state_d == DONE_WAIT);
  end

  // State and output registers; reset discards any division in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HOLD;
      r_q         <= '0;
      q_q         <= '0;
      count_q     <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      count_q     <= count_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port run, input, 1 bit: level start request; one division per run assertion.
REQ-005 The block SHALL have port dividend, input, WIDTH bits: unsigned dividend, sampled in LOAD.
REQ-006 The block SHALL have port divisor, input, WIDTH bits: unsigned divisor, sampled in LOAD.
REQ-007 The block SHALL have port quotient, output, WIDTH bits: registered quotient result.
REQ-008 The block SHALL have port remainder, output, WIDTH bits: registered remainder result.
REQ-009 The block SHALL have port busy, output, 1 bit: high in LOAD, SHIFT and TRIAL.
REQ-010 The block SHALL have port done, output, 1 bit: high only in DONE_WAIT.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: registered flag for the last operation; valid while done is high.

Function
REQ-012 The FSM SHALL have the states HOLD, LOAD, SHIFT, TRIAL and DONE_WAIT.
REQ-013 HOLD SHALL go to LOAD when run=1 and stay in HOLD otherwise.
REQ-014 LOAD SHALL latch the operands, clear the 9-bit partial remainder R, set working Q=dividend and count=0, then go to SHIFT; if divisor=0 it SHALL go to DONE_WAIT instead.
REQ-015 SHIFT SHALL shift {R,Q} left one bit with Q[0]=0, then go to TRIAL.
REQ-016 TRIAL SHALL form T=R-{0,divisor} in WIDTH+1 bits.
REQ-017 In TRIAL, if T has no borrow (T[WIDTH]=0), R SHALL become T and Q[0] SHALL become 1; otherwise R and Q SHALL be kept.
REQ-018 TRIAL SHALL increment count and go to SHIFT while count<WIDTH-1, and to DONE_WAIT otherwise.
REQ-019 DONE_WAIT SHALL stay while run=1 and go to HOLD when run=0, so a held run never starts a second operation.
REQ-020 quotient, remainder and div_by_zero SHALL update only on the clock edge entering DONE_WAIT, and SHALL hold their values through HOLD and the next operation.
REQ-021 For a nonzero divisor, the results on that edge SHALL be quotient=Q and remainder=R[WIDTH-1:0], with div_by_zero=0.
REQ-022 For divisor=0, the results on that edge SHALL be quotient={WIDTH{1}}, remainder=dividend and div_by_zero=1.
REQ-023 Latency: with run sampled high in HOLD at edge 0, done SHALL first be high after edge 2*WIDTH+1 (edge 17 for WIDTH=8); for divisor=0 it SHALL be high after edge 1.
REQ-024 Changes to dividend or divisor after LOAD SHALL have no effect on the result in progress.
REQ-025 The invariants SHALL hold in every state: busy and done are never high together, and busy=0 in HOLD.

Reset
REQ-026 While reset=1 the block SHALL be in HOLD, with quotient=0, remainder=0, div_by_zero=0, busy=0 and done=0.
REQ-027 Reset SHALL take priority over every transition, including mid-SHIFT/TRIAL; any partial result SHALL be discarded and no output SHALL update.
REQ-028 If run=1 on the first cycle after reset deasserts, the block SHALL start an operation per REQ-013.

Structure
REQ-029 A shared package div_pkg SHALL hold the state enum type and the default WIDTH constant.
REQ-030 A combinational sub-module div_step SHALL compute the WIDTH+1-bit trial subtraction and the next-R/next-Q[0] selection; FSM, counter and result registers SHALL stay in restoring_divider.

Verification
REQ-031 dividend=100, divisor=7, run pulsed -> done after 17 edges, quotient=14, remainder=2, div_by_zero=0.
REQ-032 dividend=255, divisor=1 -> quotient=255, remainder=0; then dividend=5, divisor=10 -> quotient=0, remainder=5.
REQ-033 dividend=42, divisor=0 -> done after 1 edge, quotient=255, remainder=42, div_by_zero=1, busy never high after LOAD.
REQ-034 run held high for 40 cycles with 200/3 -> exactly one operation (66 r 2); a second start occurs only after run goes low then high.
REQ-035 reset=1 asserted in the 5th TRIAL of 200/3 -> next cycle HOLD, all outputs 0; a fresh 9/4 then gives quotient=2, remainder=1.
REQ-036 Operands changed to 0/0 during busy for 77/5 -> result stays quotient=15, remainder=2, div_by_zero=0.
